sprite_cluster_pipe: RTL and testbench

SPRITE_CLUSTER_PIPE -- requirements
Module: sprite_cluster_pipe

---
 rtl/sprite_cluster_pipe_pkg.sv | 29 ++
 rtl/sprite_hit_unit.sv | 40 ++++
 rtl/sprite_cluster_pipe.sv | 154 +++++++++++++++
 tb/tb_sprite_cluster_pipe.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cluster_pipe_pkg.sv
// Shared definitions for the sprite cluster shading pipeline: attribute layout,
// register field offsets and AXI4-Lite response codes.
package sprite_cluster_pipe_pkg;

    localparam int DATA_W       = 32;
    localparam int SHORT_W      = DATA_W / 4;
    localparam int PIPE_LATENCY = 3;
    localparam int CTRL_EN_BIT  = 8;

    localparam logic [1:0] FIELD_SX   = 2'd0;
    localparam logic [1:0] FIELD_SY   = 2'd1;
    localparam logic [1:0] FIELD_TEX  = 2'd2;
    localparam logic [1:0] FIELD_CTRL = 2'd3;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0]  sx;
        logic [DATA_W-1:0]  sy;
        logic [SHORT_W-1:0] stx;
        logic [SHORT_W-1:0] sty;
        logic [SHORT_W-1:0] stw;
        logic [SHORT_W-1:0] sth;
        logic [1:0]         sh;
        logic               en;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite screen-space hit test and texel address computation (purely combinational).
module sprite_hit_unit
    import sprite_cluster_pipe_pkg::*;
#(
    parameter int TEXTURE_WIDTH = 64,
    parameter int TADDR_W       = 12
) (
    input  sprite_attr_t        attr_i,
    input  logic [DATA_W-1:0]   x_i,
    input  logic [DATA_W-1:0]   y_i,
    output logic                hit_o,
    output logic [TADDR_W-1:0]  taddr_o
);

    // Extra headroom so sx + (stw << sh) can never wrap.
    localparam int CMP_W = DATA_W + 9;

    logic [CMP_W-1:0]  x_e, y_e, sx_e, sy_e, w_e, h_e;
    logic [DATA_W-1:0] dx, dy, u, v;

    always_comb begin
        x_e  = CMP_W'(x_i);
        y_e  = CMP_W'(y_i);
        sx_e = CMP_W'(attr_i.sx);
        sy_e = CMP_W'(attr_i.sy);
        w_e  = CMP_W'(attr_i.stw) << attr_i.sh;
        h_e  = CMP_W'(attr_i.sth) << attr_i.sh;

        hit_o = attr_i.en
              && (x_e >= sx_e) && (x_e < sx_e + w_e)
              && (y_e >= sy_e) && (y_e < sy_e + h_e);

        dx = (x_i - attr_i.sx) >> attr_i.sh;
        dy = (y_i - attr_i.sy) >> attr_i.sh;
        u  = DATA_W'(attr_i.stx) + dx;
        v  = DATA_W'(attr_i.sty) + dy;
        taddr_o = TADDR_W'(u + v * DATA_W'(TEXTURE_WIDTH));
    end

endmodule

// File: rtl/sprite_cluster_pipe.sv
// Sprite cluster shader: AXI4-Lite shadow/active attribute registers feeding a
// three-stage hit / select / texel-resolve pipeline.
module sprite_cluster_pipe
    import sprite_cluster_pipe_pkg::*;
#(
    parameter int CLUSTER_SIZE   = 4,
    parameter int TEXTURE_WIDTH  = 64,
    parameter int TEXTURE_HEIGHT = 64,
    parameter int ADDR_WIDTH     = 22,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int COLOR_WIDTH    = 12,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR  = '1,
    parameter logic [COLOR_WIDTH-1:0] KEY_COLOR = 12'hF0F,
    localparam int TADDR_W = $clog2(TEXTURE_WIDTH * TEXTURE_HEIGHT)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [2:0]              awprot_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic                    frame_start_i,
    input  logic                    pix_valid_i,
    input  logic [DATA_WIDTH-1:0]   x_i,
    input  logic [DATA_WIDTH-1:0]   y_i,
    output logic [TADDR_W-1:0]      taddr_o,
    input  logic [COLOR_WIDTH-1:0]  tcolor_i,
    output logic [COLOR_WIDTH-1:0]  pixel_o,
    output logic                    pixel_valid_o
);

    localparam int SIDX_W = ADDR_WIDTH - 4;

    logic [SIDX_W-1:0] wr_sprite;
    logic [1:0]        wr_field;
    logic              wr_fire, wr_in_range;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              unused_axi;

    assign wr_sprite   = awaddr_i[ADDR_WIDTH-1:4];
    assign wr_field    = awaddr_i[3:2];
    assign wr_fire     = awvalid_i & wvalid_i & ~bvalid_q & rst_ni;
    assign wr_in_range = wr_sprite < SIDX_W'(CLUSTER_SIZE);
    assign awready_o   = wr_fire;
    assign wready_o    = wr_fire;
    assign bvalid_o    = bvalid_q;
    assign bresp_o     = bresp_q;
    assign unused_axi  = ^{awprot_i, awaddr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bvalid_q <= 1'b0;
            bresp_q  <= BRESP_OKAY;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? BRESP_OKAY : BRESP_SLVERR;
        end else if (bready_i) begin
            bvalid_q <= 1'b0;
        end
    end

    logic [CLUSTER_SIZE-1:0] hit_c;
    logic [TADDR_W-1:0]      addr_c [CLUSTER_SIZE];

    for (genvar gi = 0; gi < CLUSTER_SIZE; gi++) begin : g_sprite
        sprite_attr_t shadow_q, active_q;

        // The copy reads the pre-write shadow, so a same-cycle write lands only in shadow.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                if (frame_start_i) active_q <= shadow_q;
                if (wr_fire && wr_in_range && wr_sprite == SIDX_W'(gi)) begin
                    case (wr_field)
                        FIELD_SX:  shadow_q.sx <= wdata_i;
                        FIELD_SY:  shadow_q.sy <= wdata_i;
                        FIELD_TEX: {shadow_q.stx, shadow_q.sty, shadow_q.stw, shadow_q.sth} <= wdata_i;
                        default: begin
                            shadow_q.en <= wdata_i[CTRL_EN_BIT];
                            shadow_q.sh <= wdata_i[1:0];
                        end
                    endcase
                end
            end
        end

        sprite_hit_unit #(
            .TEXTURE_WIDTH (TEXTURE_WIDTH),
            .TADDR_W       (TADDR_W)
        ) u_hit (
            .attr_i  (active_q),
            .x_i     (x_i),
            .y_i     (y_i),
            .hit_o   (hit_c[gi]),
            .taddr_o (addr_c[gi])
        );
    end

    logic                    valid1_q, valid2_q, valid3_q, hit2_q, hit3_q;
    logic [CLUSTER_SIZE-1:0] hit1_q;
    logic [TADDR_W-1:0]      addr1_q [CLUSTER_SIZE];
    logic [TADDR_W-1:0]      taddr_q;
    logic                    sel_hit;
    logic [TADDR_W-1:0]      sel_addr;

    // Lowest index wins; the scan runs downward so the last assignment is the lowest hit.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int i = CLUSTER_SIZE - 1; i >= 0; i--) begin
            if (hit1_q[i]) begin
                sel_hit  = 1'b1;
                sel_addr = addr1_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            valid3_q <= 1'b0;
            hit1_q   <= '0;
            hit2_q   <= 1'b0;
            hit3_q   <= 1'b0;
            taddr_q  <= '0;
            for (int i = 0; i < CLUSTER_SIZE; i++) addr1_q[i] <= '0;
        end else begin
            valid1_q <= pix_valid_i;
            hit1_q   <= hit_c;
            for (int i = 0; i < CLUSTER_SIZE; i++) addr1_q[i] <= addr_c[i];
            valid2_q <= valid1_q;
            hit2_q   <= valid1_q & sel_hit;
            if (valid1_q && sel_hit) taddr_q <= sel_addr;
            valid3_q <= valid2_q;
            hit3_q   <= hit2_q;
        end
    end

    // Texel arrives one cycle after taddr; a keyed texel shows background, never a lower sprite.
    assign taddr_o       = taddr_q;
    assign pixel_valid_o = valid3_q;
    assign pixel_o       = (valid3_q && hit3_q && tcolor_i != KEY_COLOR) ? tcolor_i : BG_COLOR;

endmodule

// File: tb/tb_sprite_cluster_pipe.sv
// Randomised self-checking bench for sprite_cluster_pipe with an arithmetic reference model.
module tb_sprite_cluster_pipe;
    import sprite_cluster_pipe_pkg::*;

    localparam int N  = 4;
    localparam int TW = 64;
    localparam logic [11:0] BG  = 12'hFFF;
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk, rst_n;
    logic [21:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata;
    logic [1:0]  bresp;
    logic        frame_start, pix_valid, pixel_valid;
    logic [31:0] x, y;
    logic [11:0] taddr, tcolor, pixel;

    int n_checks = 0;
    int n_errors = 0;

    sprite_cluster_pipe dut (
        .clk_i(clk), .rst_ni(rst_n),
        .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .frame_start_i(frame_start), .pix_valid_i(pix_valid), .x_i(x), .y_i(y),
        .taddr_o(taddr), .tcolor_i(tcolor), .pixel_o(pixel), .pixel_valid_o(pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] tex_mem [4096];
    always @(posedge clk) tcolor <= tex_mem[taddr];

    // ---------------- reference model ----------------
    typedef struct {
        longint sx, sy, stx, sty, stw, sth, sh;
        bit     en;
    } mattr_t;

    mattr_t m_shadow [N];
    mattr_t m_active [N];
    longint exp_taddr = 0;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = '{0, 0, 0, 0, 0, 0, 0, 1'b0};
            m_active[k] = '{0, 0, 0, 0, 0, 0, 0, 1'b0};
        end
        exp_taddr = 0;
    endfunction

    function automatic logic [1:0] model_write(logic [21:0] a, logic [31:0] d);
        longint word = longint'(a) / 4;
        int     spr  = int'(word / 4);
        int     fld  = int'(word % 4);
        if (spr >= N) return 2'b10;
        case (fld)
            0: m_shadow[spr].sx = d;
            1: m_shadow[spr].sy = d;
            2: begin
                m_shadow[spr].stx = d[31:24];
                m_shadow[spr].sty = d[23:16];
                m_shadow[spr].stw = d[15:8];
                m_shadow[spr].sth = d[7:0];
            end
            default: begin
                m_shadow[spr].en = d[8];
                m_shadow[spr].sh = d[1:0];
            end
        endcase
        return 2'b00;
    endfunction

    function automatic void model_shade(longint px, longint py, output bit hit, output longint addr);
        mattr_t a;
        hit  = 1'b0;
        addr = 0;
        for (int k = 0; k < N; k++) begin
            a = m_active[k];
            if (!hit && a.en && px >= a.sx && px < a.sx + (a.stw << a.sh)
                     && py >= a.sy && py < a.sy + (a.sth << a.sh)) begin
                hit  = 1'b1;
                addr = ((a.stx + ((px - a.sx) >> a.sh)) + (a.sty + ((py - a.sy) >> a.sh)) * TW) % 4096;
            end
        end
    endfunction

    function automatic logic [11:0] color_of(bit hit, longint addr);
        if (hit && tex_mem[addr] != KEY) return tex_mem[addr];
        return BG;
    endfunction

    // ---------------- stimulus helpers (no comparisons except timeouts) ----------------
    task automatic axi_write(input logic [21:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit acc = 1'b0;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) begin
            #1;
            if (awready === 1'b1) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL axi_accept: awready stayed 0 after 8 cycles, required 1");
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bvalid ? bresp : 2'bxx;
        @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        m_active = m_shadow;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic shade(input logic [31:0] px, input logic [31:0] py, output logic pv_early,
                         output logic pv, output logic [11:0] pix, output logic [11:0] ta);
        @(negedge clk);
        x = px; y = py; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        ta = taddr; pv_early = pixel_valid;
        @(negedge clk);
        pv = pixel_valid; pix = pixel;
        $display("shade (%0d,%0d): taddr=%0d pixel=%h valid=%b", px, py, ta, pix, pv);
    endtask

    function automatic logic [31:0] tex_word(int stx, int sty, int stw, int sth);
        return {8'(stx), 8'(sty), 8'(stw), 8'(sth)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic pe, pv; logic [11:0] pix, ta;
        rst_n = 1'b0; awvalid = 1'b1; wvalid = 1'b1; awaddr = '0; wdata = 32'h55;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (pixel_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pixel_valid: got %b required 0", pixel_valid); end
        n_checks++; if (pixel !== BG) begin n_errors++; $display("FAIL reset_pixel: got %h required %h", pixel, BG); end
        n_checks++; if (taddr !== 12'd0) begin n_errors++; $display("FAIL reset_taddr: got %0d required 0", taddr); end
        n_checks++; if (bvalid !== 1'b0 || bresp !== 2'b00) begin n_errors++; $display("FAIL reset_bchan: got bvalid=%b bresp=%b required 0/00", bvalid, bresp); end
        n_checks++; if (awready !== 1'b0 || wready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got aw=%b w=%b required 0/0", awready, wready); end
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        shade(32'd3, 32'd3, pe, pv, pix, ta);
        n_checks++; if (pv !== 1'b1 || pix !== BG) begin n_errors++; $display("FAIL reset_empty_shade: got valid=%b pixel=%h required 1/%h", pv, pix, BG); end
    endtask

    task automatic test_basic();
        logic [21:0] adr [4] = '{22'd0, 22'd4, 22'd8, 22'd12};
        logic [31:0] dat [4];
        logic [1:0]  r, er;
        logic pe, pv; logic [11:0] pix, ta;
        dat = '{32'd10, 32'd20, tex_word(0, 0, 8, 8), 32'h100};
        for (int i = 0; i < 4; i++) begin
            axi_write(adr[i], dat[i], r);
            er = model_write(adr[i], dat[i]);
            n_checks++; if (r !== er) begin n_errors++; $display("FAIL basic_bresp: got %b required %b", r, er); end
        end
        frame();
        tex_mem[131] = 12'h123;
        shade(32'd13, 32'd22, pe, pv, pix, ta);
        n_checks++; if (pe !== 1'b0) begin n_errors++; $display("FAIL basic_latency_early: got pixel_valid=%b at 2 cycles required 0", pe); end
        n_checks++; if (pv !== 1'b1) begin n_errors++; $display("FAIL basic_latency: got pixel_valid=%b at 3 cycles required 1", pv); end
        n_checks++; if (ta !== 12'd131) begin n_errors++; $display("FAIL basic_taddr: got %0d required 131", ta); end
        n_checks++; if (pix !== 12'h123) begin n_errors++; $display("FAIL basic_pixel: got %h required 123", pix); end
        exp_taddr = 131;
    endtask

    task automatic test_scale();
        logic [1:0] r;
        logic pe, pv; logic [11:0] pix, ta;
        axi_write(22'd12, 32'h101, r);
        void'(model_write(22'd12, 32'h101));
        frame();
        tex_mem[455] = 12'h456;
        shade(32'd25, 32'd35, pe, pv, pix, ta);
        n_checks++; if (ta !== 12'd455) begin n_errors++; $display("FAIL scale_taddr: got %0d required 455", ta); end
        n_checks++; if (pix !== 12'h456) begin n_errors++; $display("FAIL scale_pixel: got %h required 456", pix); end
        shade(32'd26, 32'd36, pe, pv, pix, ta);
        n_checks++; if (pv !== 1'b1 || pix !== BG) begin n_errors++; $display("FAIL scale_edge_miss: got valid=%b pixel=%h required 1/%h", pv, pix, BG); end
        n_checks++; if (ta !== 12'd455) begin n_errors++; $display("FAIL scale_taddr_hold: got %0d required 455", ta); end
        exp_taddr = 455;
    endtask

    task automatic test_priority_key();
        logic [21:0] adr [8] = '{22'd0, 22'd4, 22'd8, 22'd12, 22'd32, 22'd36, 22'd40, 22'd44};
        logic [31:0] dat [8];
        logic [1:0] r;
        logic pe, pv; logic [11:0] pix, ta;
        dat = '{32'd0, 32'd0, tex_word(0, 0, 8, 8), 32'h100, 32'd0, 32'd0, tex_word(16, 16, 8, 8), 32'h100};
        for (int i = 0; i < 8; i++) begin
            axi_write(adr[i], dat[i], r);
            void'(model_write(adr[i], dat[i]));
        end
        frame();
        tex_mem[325]  = KEY;
        tex_mem[1365] = 12'h0AB;
        shade(32'd5, 32'd5, pe, pv, pix, ta);
        n_checks++; if (pix !== BG) begin n_errors++; $display("FAIL key_no_fallthrough: got %h required %h", pix, BG); end
        n_checks++; if (ta !== 12'd325) begin n_errors++; $display("FAIL key_taddr: got %0d required 325", ta); end
        axi_write(22'd12, 32'h0, r);
        void'(model_write(22'd12, 32'h0));
        frame();
        shade(32'd5, 32'd5, pe, pv, pix, ta);
        n_checks++; if (pix !== 12'h0AB || ta !== 12'd1365) begin n_errors++; $display("FAIL prio_sprite2: got pixel=%h taddr=%0d required 0ab/1365", pix, ta); end
        exp_taddr = 1365;
    endtask

    task automatic test_slverr();
        logic pe, pv; logic [11:0] pix, ta;
        bit hit; longint a;
        @(negedge clk);
        awaddr = 22'(N * 16); wdata = 32'hDEAD; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        n_checks++; if (awready !== 1'b1) begin n_errors++; $display("FAIL slverr_accept: got awready=%b required 1", awready); end
        void'(model_write(22'(N * 16), 32'hDEAD));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0) begin
                n_errors++;
                $display("FAIL slverr_hold%0d: got bvalid=%b bresp=%b awready=%b required 1/10/0", i, bvalid, bresp, awready);
            end
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        n_checks++; if (bvalid !== 1'b0) begin n_errors++; $display("FAIL slverr_release: got bvalid=%b required 0", bvalid); end
        frame();
        shade(32'd5, 32'd5, pe, pv, pix, ta);
        model_shade(5, 5, hit, a);
        n_checks++; if (pix !== color_of(hit, a)) begin n_errors++; $display("FAIL slverr_no_change: got %h required %h", pix, color_of(hit, a)); end
    endtask

    task automatic test_shadow();
        logic [1:0] r;
        logic pe, pv; logic [11:0] pix, ta;
        bit hit; longint a;
        logic [31:0] pts [3][2] = '{'{32'd5, 32'd5}, '{32'd103, 32'd5}, '{32'd203, 32'd5}};
        axi_write(22'd32, 32'd100, r);
        void'(model_write(22'd32, 32'd100));
        shade(32'd5, 32'd5, pe, pv, pix, ta);
        model_shade(5, 5, hit, a);
        n_checks++; if (pix !== color_of(hit, a)) begin n_errors++; $display("FAIL shadow_no_frame: got %h required %h", pix, color_of(hit, a)); end
        @(negedge clk);
        awaddr = 22'd32; wdata = 32'd200; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; frame_start = 1'b1;
        #1;
        n_checks++; if (awready !== 1'b1) begin n_errors++; $display("FAIL shadow_coincide_accept: got awready=%b required 1", awready); end
        m_active = m_shadow;
        void'(model_write(22'd32, 32'd200));
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
        n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_errors++; $display("FAIL shadow_coincide_bresp: got %b/%b required 1/00", bvalid, bresp); end
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                shade(pts[i][0], pts[i][1], pe, pv, pix, ta);
                model_shade(pts[i][0], pts[i][1], hit, a);
                if (hit) exp_taddr = a;
                n_checks++;
                if (pix !== color_of(hit, a) || ta !== 12'(exp_taddr)) begin
                    n_errors++;
                    $display("FAIL shadow_phase%0d_pt%0d: got pixel=%h taddr=%0d required %h/%0d", p, i, pix, ta, color_of(hit, a), exp_taddr);
                end
            end
            if (p == 0) frame();
        end
    endtask

    task automatic random_config(input longint base);
        logic [1:0] r, er;
        logic [31:0] d;
        for (int k = 0; k < N; k++) begin
            for (int f = 0; f < 4; f++) begin
                case (f)
                    0, 1:    d = 32'(base + longint'($urandom_range(0, 60)));
                    2:       d = tex_word($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15));
                    default: d = {23'd0, ($urandom_range(0, 4) != 0), 6'd0, 2'($urandom_range(0, 3))};
                endcase
                axi_write(22'(k * 16 + f * 4), d, r);
                er = model_write(22'(k * 16 + f * 4), d);
                n_checks++; if (r !== er) begin n_errors++; $display("FAIL rand_cfg_bresp s%0d f%0d: got %b required %b", k, f, r, er); end
            end
        end
        axi_write(22'($urandom_range(N, 15) * 16), $urandom, r);
        n_checks++; if (r !== 2'b10) begin n_errors++; $display("FAIL rand_oob_bresp: got %b required 10", r); end
    endtask

    task automatic test_random_stream();
        localparam int L = 40;
        localparam int M = L / 2;
        bit          e_pv [L];
        logic [11:0] e_pix [L];
        logic [11:0] e_ta [L];
        bit hit; longint a, base;
        for (int rnd = 0; rnd < 3; rnd++) begin
            base = (rnd == 2) ? 64'hFFFF_FF80 : 0;
            random_config(base);
            frame();
            random_config(base);
            for (int c = 0; c < L + 3; c++) begin
                @(negedge clk);
                if (c >= 2 && c - 2 < L) begin
                    n_checks++;
                    if (taddr !== e_ta[c-2]) begin n_errors++; $display("FAIL rand%0d_taddr c%0d: got %0d required %0d", rnd, c - 2, taddr, e_ta[c-2]); end
                end
                if (c >= 3) begin
                    n_checks++;
                    if (pixel_valid !== e_pv[c-3] || (e_pv[c-3] && pixel !== e_pix[c-3])) begin
                        n_errors++;
                        $display("FAIL rand%0d_pixel c%0d: got valid=%b pixel=%h required %b/%h", rnd, c - 3, pixel_valid, pixel, e_pv[c-3], e_pix[c-3]);
                    end
                end
                if (c < L) begin
                    x = 32'(base + longint'($urandom_range(0, 127)));
                    y = 32'(base + longint'($urandom_range(0, 127)));
                    pix_valid = ($urandom_range(0, 4) != 0);
                    frame_start = (c == M);
                    e_pv[c] = pix_valid;
                    if (pix_valid) begin
                        model_shade(x, y, hit, a);
                        if (hit) exp_taddr = a;
                        e_pix[c] = color_of(hit, a);
                    end
                    e_ta[c] = 12'(exp_taddr);
                    if (c == M) m_active = m_shadow;
                end else begin
                    pix_valid = 1'b0;
                    frame_start = 1'b0;
                end
            end
            $display("random round %0d streamed %0d cycles", rnd, L);
        end
    endtask

    task automatic test_reset_midstream();
        logic [21:0] adr [4] = '{22'd0, 22'd4, 22'd8, 22'd12};
        logic [31:0] dat [4];
        logic [1:0] r;
        logic pe, pv; logic [11:0] pix, ta;
        dat = '{32'd0, 32'd0, tex_word(0, 0, 8, 8), 32'h101};
        for (int i = 0; i < 4; i++) begin
            axi_write(adr[i], dat[i], r);
            void'(model_write(adr[i], dat[i]));
        end
        frame();
        @(negedge clk);
        awaddr = 22'd12; wdata = 32'h101; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++; if (bvalid !== 1'b1) begin n_errors++; $display("FAIL rstmid_pending: got bvalid=%b required 1", bvalid); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c >= 3 && c < 8) begin
                n_checks++; if (pixel_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_stream c%0d: got pixel_valid=%b required 1", c, pixel_valid); end
            end
            if (c < 8) begin
                x = 32'(c % 8); y = 32'd1; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            if (c == 8) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if (pixel_valid !== 1'b0 || pixel !== BG || taddr !== 12'd0) begin
                    n_errors++;
                    $display("FAIL rstmid_async: got valid=%b pixel=%h taddr=%0d required 0/%h/0", pixel_valid, pixel, taddr, BG);
                end
            end
            if (c == 11) begin
                rst_n = 1'b1;
                bready = 1'b1;
                model_reset();
            end
            if (c > 11) begin
                n_checks++;
                if (pixel_valid !== 1'b0 || bvalid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rstmid_quiet c%0d: got pixel_valid=%b bvalid=%b required 0/0", c, pixel_valid, bvalid);
                end
            end
        end
        shade(32'd2, 32'd1, pe, pv, pix, ta);
        n_checks++;
        if (pv !== 1'b1 || pix !== BG || ta !== 12'd0) begin
            n_errors++;
            $display("FAIL rstmid_disabled: got valid=%b pixel=%h taddr=%0d required 1/%h/0", pv, pix, ta, BG);
        end
    endtask

    initial begin
        awaddr = '0; awprot = 3'b000; awvalid = 1'b0; wvalid = 1'b0; wdata = '0; bready = 1'b1;
        frame_start = 1'b0; pix_valid = 1'b0; x = '0; y = '0; rst_n = 1'b0;
        for (int i = 0; i < 4096; i++)
            tex_mem[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom_range(0, 4094));
        model_reset();
        test_reset();
        test_basic();
        test_scale();
        test_priority_key();
        test_slverr();
        test_shadow();
        test_random_stream();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
